led_flow_ctrl: RTL

Sequencer for the LED flow display. Generates its own step tick from the system clock and steps an LED_NUM-bit pattern in one of four modes: rotate-left, rotate-right, bounce or blink. Step speed is selectable, and the block supports start, stop and hold control. It sits between the board push-button/switch logic and the LED pins, and replaces the free-running divider-plus-shifter arrangement.

---
 rtl/led_flow_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/led_flow_ctrl.sv
// LED flow sequencer: self-timed rotate-left/right, bounce and blink patterns with start/stop/hold.
// Define LED_FLOW_ACTIVE_LOW_EN to drive led = ~pattern for active-low boards.
module led_flow_ctrl #(
    parameter int LED_NUM  = 8,
    parameter int BASE_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led,
    output logic               busy,
    output logic               step_pulse
);
    localparam int CW = $clog2(BASE_DIV);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam logic [1:0] MODE_LEFT   = 2'd0;
    localparam logic [1:0] MODE_RIGHT  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

`ifdef LED_FLOW_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif
    // XOR mask applied to the pattern on its way to the pins; also the dark/reset value of led.
    localparam logic [LED_NUM-1:0] LED_DARK = {LED_NUM{ACTIVE_LOW}};

    logic [1:0]         state_reg, state_next;
    logic [LED_NUM-1:0] pattern_reg, pattern_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               dir_reg, dir_next;
    logic [1:0]         mode_reg, mode_next;
    logic [LED_NUM-1:0] led_reg;
    logic               busy_reg;
    logic               step_reg, step_next;

    logic [31:0]        period;
    logic [LED_NUM-1:0] adv_pattern;
    logic               adv_dir;
    logic [LED_NUM-1:0] init_pattern;

    // Pattern after one advance in the latched mode.
    always_comb begin
        adv_pattern = ~pattern_reg;
        adv_dir     = dir_reg;
        case (mode_reg)
            MODE_LEFT:  adv_pattern = {pattern_reg[LED_NUM-2:0], pattern_reg[LED_NUM-1]};
            MODE_RIGHT: adv_pattern = {pattern_reg[0], pattern_reg[LED_NUM-1:1]};
            MODE_BOUNCE: begin
                if (dir_reg == DIR_LEFT) begin
                    adv_pattern = pattern_reg << 1;
                    if (adv_pattern[LED_NUM-1]) adv_dir = DIR_RIGHT;
                end else begin
                    adv_pattern = pattern_reg >> 1;
                    if (adv_pattern[0]) adv_dir = DIR_LEFT;
                end
            end
            default: adv_pattern = ~pattern_reg;
        endcase
    end

    always_comb begin
        case (mode)
            MODE_RIGHT:  init_pattern = {1'b1, {(LED_NUM-1){1'b0}}};
            MODE_LEFT,
            MODE_BOUNCE: init_pattern = {{(LED_NUM-1){1'b0}}, 1'b1};
            default:     init_pattern = '1;
        endcase
    end

    always_comb begin
        period       = 32'(BASE_DIV) >> speed;
        state_next   = state_reg;
        pattern_next = pattern_reg;
        cnt_next     = cnt_reg;
        dir_next     = dir_reg;
        mode_next    = mode_reg;
        step_next    = 1'b0;

        if (stop && state_reg != IDLE) begin
            state_next   = IDLE;
            pattern_next = '0;
            cnt_next     = '0;
            dir_next     = DIR_LEFT;
        end else if (start) begin
            state_next   = RUN;
            mode_next    = mode;
            cnt_next     = '0;
            dir_next     = DIR_LEFT;
            pattern_next = init_pattern;
        end else if (state_reg == IDLE) begin
            pattern_next = '0;
            cnt_next     = '0;
        end else if (hold) begin
            state_next = PAUSE;
        end else begin
            // ">=" lets a mid-interval switch to a shorter period step on the very next cycle.
            state_next = RUN;
            if (32'(cnt_reg) >= period - 32'd1) begin
                cnt_next     = '0;
                step_next    = 1'b1;
                pattern_next = adv_pattern;
                dir_next     = adv_dir;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pattern_reg <= '0;
            cnt_reg     <= '0;
            dir_reg     <= DIR_LEFT;
            mode_reg    <= MODE_LEFT;
            led_reg     <= LED_DARK;
            busy_reg    <= 1'b0;
            step_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
            mode_reg    <= mode_next;
            led_reg     <= pattern_next ^ LED_DARK;
            busy_reg    <= (state_next != IDLE);
            step_reg    <= step_next;
        end
    end

    assign led        = led_reg;
    assign busy       = busy_reg;
    assign step_pulse = step_reg;
endmodule
